// File: rtl/stall_sequencer_if.sv
// Decoder and memory handshake bundle for stall_sequencer.
// master drives decoder fields and mem_ack; slave is the sequencer.
interface stall_sequencer_if;
  logic        dec_valid;
  logic [3:0]  dec_group;
  logic        dec_causes_stall;
  logic        dec_is_store;
  logic        mem_ack;
  logic        stall_out;
  logic        mem_req;
  logic        mem_we;
  logic        irq_mask;
  logic [1:0]  state_out;
  logic        mem_err;
  logic [15:0] stall_cycles;

  modport master (
    output dec_valid,
    output dec_group,
    output dec_causes_stall,
    output dec_is_store,
    output mem_ack,
    input  stall_out,
    input  mem_req,
    input  mem_we,
    input  irq_mask,
    input  state_out,
    input  mem_err,
    input  stall_cycles
  );

  modport slave (
    input  dec_valid,
    input  dec_group,
    input  dec_causes_stall,
    input  dec_is_store,
    input  mem_ack,
    output stall_out,
    output mem_req,
    output mem_we,
    output irq_mask,
    output state_out,
    output mem_err,
    output stall_cycles
  );
endinterface

// File: rtl/stall_sequencer.sv
// Pipeline stall sequencer: freezes fetch/decode for memory, control-flow and system ops.
// Optional MEM timeout with mem_err pulse is compiled in by OPT_STALL_SEQUENCER_TIMEOUT_EN.
module stall_sequencer #(
  parameter int unsigned CTRL_FLOW_BUBBLES = 2,
  parameter int unsigned MEM_TIMEOUT       = 255
) (
  input logic               clk,
  input logic               rst_n,
  stall_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StMem  = 2'd1,
    StCtrl = 2'd2,
    StSys  = 2'd3
  } state_e;

  localparam logic [3:0] BubbleLoad = 4'(CTRL_FLOW_BUBBLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  bubble_q, bubble_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        trigger;
  logic        stall;
  logic        group_ctrl;
  logic        mem_timeout;

  // Reset gates the trigger so stall/irq outputs drop without waiting for a clock.
  assign group_ctrl = (bus.dec_group == 4'd2) || (bus.dec_group == 4'd3) ||
                      (bus.dec_group == 4'd4);
  assign trigger = rst_n && (state_q == StRun) && bus.dec_valid && bus.dec_causes_stall &&
                   (group_ctrl || (bus.dec_group == 4'd5) || (bus.dec_group == 4'd6));
  assign stall   = trigger || (state_q != StRun);

`ifdef OPT_STALL_SEQUENCER_TIMEOUT_EN
  localparam logic [7:0] MemLimit = 8'(MEM_TIMEOUT - 1);

  logic [7:0] mem_cnt_q, mem_cnt_d;
  logic       mem_err_q;

  // mem_ack in the limit cycle wins over the timeout.
  assign mem_timeout = (state_q == StMem) && (mem_cnt_q == MemLimit) && !bus.mem_ack;

  always_comb begin
    mem_cnt_d = 8'd0;
    if ((state_q == StMem) && (state_d == StMem)) begin
      mem_cnt_d = mem_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_cnt_q <= 8'd0;
      mem_err_q <= 1'b0;
    end else begin
      mem_cnt_q <= mem_cnt_d;
      mem_err_q <= mem_timeout;
    end
  end

  assign bus.mem_err = mem_err_q;
`else
  assign mem_timeout = 1'b0;
  assign bus.mem_err = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    bubble_d = bubble_q;
    mem_we_d = mem_we_q;
    unique case (state_q)
      StRun: begin
        if (trigger) begin
          if (bus.dec_group == 4'd5) begin
            state_d  = StMem;
            mem_we_d = bus.dec_is_store;
          end else if (bus.dec_group == 4'd6) begin
            state_d = StSys;
          end else begin
            state_d  = StCtrl;
            bubble_d = BubbleLoad;
          end
        end
      end
      StMem: begin
        if (bus.mem_ack || mem_timeout) begin
          state_d  = StRun;
          mem_we_d = 1'b0;
        end
      end
      StCtrl: begin
        if (bubble_q == 4'd0) begin
          state_d = StRun;
        end else begin
          bubble_d = bubble_q - 4'd1;
        end
      end
      StSys: begin
        state_d = StRun;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      bubble_q    <= 4'd0;
      mem_we_q    <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      bubble_q    <= bubble_d;
      mem_we_q    <= mem_we_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_out    = stall;
  assign bus.irq_mask     = stall;
  assign bus.mem_req      = (state_q == StMem);
  assign bus.mem_we       = (state_q == StMem) && mem_we_q;
  assign bus.state_out    = state_q;
  assign bus.stall_cycles = stall_cnt_q;

  a_param_range: assert property (@(posedge clk) disable iff (!rst_n)
    (CTRL_FLOW_BUBBLES >= 1) && (CTRL_FLOW_BUBBLES <= 15) &&
    (MEM_TIMEOUT >= 2) && (MEM_TIMEOUT <= 255));

  a_we_needs_req: assert property (@(posedge clk) disable iff (!rst_n)
    bus.mem_we |-> bus.mem_req);

  a_bubble_bound: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StCtrl) |-> (bubble_q <= BubbleLoad));

endmodule

// File: tb/tb_stall_sequencer.sv
// Scoreboard bench for stall_sequencer: episode-level reference model feeds an expected-output
// queue, a negedge monitor pops and compares every presented cycle.
module tb_stall_sequencer;

  localparam int BUB = 2;
`ifdef OPT_STALL_SEQUENCER_TIMEOUT_EN
  localparam int MT    = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int MT    = 255;
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]  st;
    logic        stall;
    logic        req;
    logic        we;
    logic        irq;
    logic        err;
    logic [15:0] sc;
  } obs_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  obs_t        exp_q[$];
  logic [15:0] sc_exp;
  logic        err_next;

  stall_sequencer_if bus ();

  stall_sequencer #(
    .CTRL_FLOW_BUBBLES (BUB),
    .MEM_TIMEOUT       (MT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t get_obs();
    obs_t a;
    a.st    = bus.state_out;
    a.stall = bus.stall_out;
    a.req   = bus.mem_req;
    a.we    = bus.mem_we;
    a.irq   = bus.irq_mask;
    a.err   = bus.mem_err;
    a.sc    = bus.stall_cycles;
    return a;
  endfunction

  function automatic void check_obs(input obs_t e, input string name);
    obs_t a;
    a = get_obs();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s @%0t: got st=%0d stall=%b req=%b we=%b irq=%b err=%b sc=%0d, want st=%0d stall=%b req=%b we=%b irq=%b err=%b sc=%0d",
               name, $time, a.st, a.stall, a.req, a.we, a.irq, a.err, a.sc,
               e.st, e.stall, e.req, e.we, e.irq, e.err, e.sc);
    end
  endfunction

  function automatic logic rnd1();
    return 1'($urandom);
  endfunction

  function automatic logic [3:0] rnd4();
    return 4'($urandom);
  endfunction

  // Monitor: every cycle that has an expectation queued is compared at the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      check_obs(exp_q.pop_front(), "cycle");
    end
  end

  // One clock cycle of stimulus plus the outputs the rules predict for it.
  task automatic step(input logic v, input logic [3:0] g, input logic cs, input logic st,
                      input logic ack, input logic [1:0] es, input logic estall,
                      input logic ewe);
    obs_t e;
    @(posedge clk);
    #1;
    rst_n                = 1'b1;
    bus.dec_valid        = v;
    bus.dec_group        = g;
    bus.dec_causes_stall = cs;
    bus.dec_is_store     = st;
    bus.mem_ack          = ack;
    e.st    = es;
    e.stall = estall;
    e.req   = (es == 2'd1);
    e.we    = ewe;
    e.irq   = estall;
    e.err   = err_next;
    e.sc    = sc_exp;
    err_next = 1'b0;
    if (estall && (sc_exp != 16'hFFFF)) sc_exp = sc_exp + 16'd1;
    exp_q.push_back(e);
  endtask

  // Asynchronous reset inside a cycle; outputs must clear before any clock edge.
  // rst_n is released by the next step.
  task automatic do_reset();
    obs_t z;
    @(posedge clk);
    #1;
    bus.dec_valid = 1'b0;
    bus.mem_ack   = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    z = '0;
    check_obs(z, "async_reset");
    sc_exp   = 16'd0;
    err_next = 1'b0;
  endtask

  // One instruction and the whole stall episode it causes; abort_at>0 resets in that cycle.
  task automatic episode(input logic v, input logic [3:0] g, input logic cs, input logic st,
                         input int ack_at, input int abort_at);
    logic trig;
    logic to;
    int   len;
    trig = v && cs && (g >= 4'd2) && (g <= 4'd6);
    step(v, g, cs, st, rnd1(), 2'd0, trig, 1'b0);
    if (!trig) return;
    if (g == 4'd5) begin
      to  = TO_EN && (ack_at > MT);
      len = to ? MT : ack_at;
      for (int i = 1; i <= len; i++) begin
        if (i == abort_at) begin
          do_reset();
          return;
        end
        step(rnd1(), rnd4(), rnd1(), rnd1(), (i == ack_at), 2'd1, 1'b1, st);
      end
      err_next = to;
    end else if (g == 4'd6) begin
      if (abort_at == 1) begin
        do_reset();
        return;
      end
      step(rnd1(), rnd4(), rnd1(), rnd1(), rnd1(), 2'd3, 1'b1, 1'b0);
    end else begin
      for (int i = 1; i <= BUB; i++) begin
        if (i == abort_at) begin
          do_reset();
          return;
        end
        step(rnd1(), rnd4(), rnd1(), rnd1(), rnd1(), 2'd2, 1'b1, 1'b0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    obs_t z;
    errors               = 0;
    checks               = 0;
    sc_exp               = 16'd0;
    err_next             = 1'b0;
    rst_n                = 1'b1;
    bus.dec_valid        = 1'b0;
    bus.dec_group        = 4'd0;
    bus.dec_causes_stall = 1'b0;
    bus.dec_is_store     = 1'b0;
    bus.mem_ack          = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    z = '0;
    check_obs(z, "reset_state");
    repeat (2) @(posedge clk);

    episode(1'b1, 4'd5, 1'b1, 1'b1, 3, 0);   // store, ack in 3rd MEM cycle
    episode(1'b1, 4'd3, 1'b1, 1'b0, 1, 0);   // control flow bubbles
    episode(1'b1, 4'd6, 1'b1, 1'b0, 1, 0);   // single SYS cycle
    episode(1'b1, 4'd5, 1'b1, 1'b0, 12, 0);  // no ack within timeout window
    episode(1'b1, 4'd5, 1'b1, 1'b1, 4, 0);   // ack exactly at the limit cycle
    episode(1'b1, 4'd5, 1'b1, 1'b1, 1, 0);   // immediate ack
    episode(1'b1, 4'd3, 1'b1, 1'b0, 1, 2);   // reset in 2nd CTRL cycle
    episode(1'b1, 4'd1, 1'b0, 1'b0, 1, 0);   // no stall after reset
    episode(1'b1, 4'd5, 1'b1, 1'b1, 12, 2);  // reset mid-MEM
    episode(1'b1, 4'd7, 1'b1, 1'b0, 1, 0);   // undefined group stays in RUN
    episode(1'b1, 4'd2, 1'b0, 1'b0, 1, 0);   // no causes_stall flag

    for (int n = 0; n < 300; n++) begin
      logic       v;
      logic [3:0] g;
      logic       cs;
      int         abort_at;
      v        = ($urandom % 4) != 0;
      g        = (($urandom % 3) == 0) ? rnd4() : 4'($urandom_range(2, 6));
      cs       = ($urandom % 4) != 0;
      abort_at = (($urandom % 20) == 0) ? int'($urandom_range(1, 3)) : 0;
      episode(v, g, cs, rnd1(), int'($urandom_range(1, 7)), abort_at);
      repeat ($urandom % 3) episode(1'b0, rnd4(), rnd1(), rnd1(), 1, 0);
    end

    episode(1'b0, 4'd0, 1'b0, 1'b0, 1, 0);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
